regfile_dbg_access: RTL and testbench
=====================================

// Module: regfile_dbg_access
// PURPOSE
//  Debug initiator for the integer register file's read/write ports. In RUN it passes core
//  port signals straight through. On halt it takes over the ports, serves single debug
//  reads/writes over a valid/ready channel, and can stream x0..x31 out in sequence (dump).
//  Sits between the core datapath and the register file, driving its raddr/waddr/wdata/reg_wr.
// PARAMETERS
//  XLEN   32  register data width
//  AW     5   register address width
//  NREGS  32  registers covered by dump; indices 0..NREGS-1
// PORTS
//  clk           in   1     clock; all state updates on posedge
//  rst           in   1     synchronous, active-high reset
//  halt_req      in   1     request core halt and debug ownership of the ports
//  halted        out  1     1 = debug owns the ports; core must stall
//  core_reg_wr   in   1     core write enable
//  core_waddr    in   AW    core write address
//  core_wdata    in   XLEN  core write data
//  core_raddr1   in   AW    core read address 1
//  core_raddr2   in   AW    core read address 2
//  rf_reg_wr     out  1     to register file write enable
//  rf_waddr      out  AW    to register file write address
//  rf_wdata      out  XLEN  to register file write data
//  rf_raddr1     out  AW    to register file read address 1
//  rf_raddr2     out  AW    to register file read address 2
//  rf_rdata1     in   XLEN  register file async read data 1; x0 reads 0
//  dbg_valid     in   1     debug command valid
//  dbg_ready     out  1     debug command accepted when valid & ready
//  dbg_we        in   1     1 = write, 0 = read
//  dbg_addr      in   AW    target register
//  dbg_wdata     in   XLEN  write data
//  dump_start    in   1     start a full-register dump; sampled only in HALT
//  rsp_valid     out  1     response valid; held until rsp_ready
//  rsp_ready     in   1     response consumer ready
//  rsp_data      out  XLEN  read data, or write echo
//  rsp_addr      out  AW    register index of the response
//  rsp_last      out  1     1 on final dump beat and on every single-command response
// BEHAVIOUR
//  Reset: state=RUN, halted=0, dbg_ready=0, rsp_valid=0, rsp_data/addr=0, rsp_last=0, dump cnt=0.
//   Reset aborts any transaction or dump. The ports return to pass-through in the next cycle.
//  States: RUN, DRAIN, HALT, WR, RD, RSP, DUMP_RD, DUMP_RSP.
//  RUN: rf_* = core_* (combinational). halted=0, dbg_ready=0.
//   halt_req=1 -> DRAIN.
//  DRAIN: one cycle, still pass-through, so an in-flight core write lands -> HALT.
//  HALT..DUMP_RSP: halted=1. rf_raddr2=0. rf_reg_wr=0 except in WR.
//  HALT: dbg_ready=1.
//   halt_req=0 -> RUN (no command accepted that cycle).
//   Else dump_start=1 -> DUMP_RD, cnt=0. dump_start has priority over dbg_valid in the same cycle.
//   Else dbg_valid: latch we/addr/wdata -> WR if we=1, else RD.
//  WR: rf_reg_wr=1, rf_waddr=addr, rf_wdata=wdata for exactly one cycle. The write commits on
//   that cycle's negedge. Response: rsp_data = (addr==0) ? 0 : wdata -> RSP.
//  RD: rf_raddr1=addr. Capture rf_rdata1 into rsp_data at cycle end -> RSP.
//   Latency from accept to rsp_valid = 2 cycles (reads and writes).
//  RSP: rsp_valid=1 with stable data/addr, rsp_last=1.
//   rsp_ready=1 -> HALT.
//  DUMP_RD: rf_raddr1=cnt. Capture rf_rdata1 -> DUMP_RSP.
//  DUMP_RSP: rsp_valid=1, rsp_addr=cnt, rsp_last=(cnt==NREGS-1).
//   On rsp_ready: if last -> HALT, cnt=0; else cnt++ -> DUMP_RD.
//   Each beat takes at least 2 cycles.
//  halt_req dropped mid-command or mid-dump: the operation completes, then HALT exits to RUN.
//  Ordering: a read accepted after a write to the same register returns the new value.
//  cnt is AW+1 bits wide, so it never wraps before the last compare.
// STRUCTURE
//  Package regfile_dbg_pkg: dbg_state_e enum, XLEN/AW localparams, dbg_cmd_t struct {we,addr,wdata}.
//  Sub-module regfile_port_mux: combinational selection between core_* and FSM-driven port values,
//   keyed on the halted-owner select.
// TESTING
//  1. Reset, halt_req=0, core_reg_wr=1 waddr=5 -> rf_* mirror core_*, halted=0, rsp_valid=0.
//  2. halt_req=1 -> halted=1 two cycles later. Write x7=0xDEADBEEF -> rf_reg_wr pulses 1 cycle,
//     rsp_data=0xDEADBEEF. Read x7 -> rsp_data=0xDEADBEEF, addr=7, last=1.
//  3. Write x0=0x1234, then read x0 -> both responses rsp_data=0.
//  4. Dump with rsp_ready toggling 1/0 -> 32 beats, addr 0..31 in order, data matches model,
//     rsp_last only on addr 31, data stable while stalled.
//  5. dump_start and dbg_valid in the same cycle -> dump runs, command not accepted (dbg_ready
//     drops). Drop halt_req mid-dump -> dump completes, then RUN.
//  6. rst=1 during DUMP_RSP (cnt=12) -> next cycle RUN, rsp_valid=0, halted=0, pass-through restored.

Source files
------------

// File: rtl/regfile_dbg_pkg.sv
// Shared types and sizes for the register-file debug initiator.
package regfile_dbg_pkg;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned NREGS = 32;
  localparam int unsigned CNT_W = AW + 1;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALT,
    ST_WR,
    ST_RD,
    ST_RSP,
    ST_DUMP_RD,
    ST_DUMP_RSP
  } dbg_state_e;

  typedef struct packed {
    logic            we;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] wdata;
  } dbg_cmd_t;
endpackage

// File: rtl/regfile_port_mux.sv
// Selects between core port values and debug-owned port values for the register file.
module regfile_port_mux
  import regfile_dbg_pkg::*;
(
  input  logic            sel,
  input  logic            core_reg_wr,
  input  logic [AW-1:0]   core_waddr,
  input  logic [XLEN-1:0] core_wdata,
  input  logic [AW-1:0]   core_raddr1,
  input  logic [AW-1:0]   core_raddr2,
  input  logic            dbg_reg_wr,
  input  logic [AW-1:0]   dbg_waddr,
  input  logic [XLEN-1:0] dbg_wdata,
  input  logic [AW-1:0]   dbg_raddr1,
  output logic            rf_reg_wr,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [AW-1:0]   rf_raddr1,
  output logic [AW-1:0]   rf_raddr2
);

  always_comb begin
    rf_reg_wr = core_reg_wr;
    rf_waddr  = core_waddr;
    rf_wdata  = core_wdata;
    rf_raddr1 = core_raddr1;
    rf_raddr2 = core_raddr2;
    if (sel) begin
      rf_reg_wr = dbg_reg_wr;
      rf_waddr  = dbg_waddr;
      rf_wdata  = dbg_wdata;
      rf_raddr1 = dbg_raddr1;
      rf_raddr2 = '0;
    end
  end

endmodule

// File: rtl/regfile_dbg_access.sv
// Debug initiator: passes core register-file traffic through in RUN, and once halted
// serves single debug reads/writes and full-register dumps over valid/ready channels.
module regfile_dbg_access
  import regfile_dbg_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            halt_req,
  output logic            halted,
  input  logic            core_reg_wr,
  input  logic [AW-1:0]   core_waddr,
  input  logic [XLEN-1:0] core_wdata,
  input  logic [AW-1:0]   core_raddr1,
  input  logic [AW-1:0]   core_raddr2,
  output logic            rf_reg_wr,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [AW-1:0]   rf_raddr1,
  output logic [AW-1:0]   rf_raddr2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic            dbg_valid,
  output logic            dbg_ready,
  input  logic            dbg_we,
  input  logic [AW-1:0]   dbg_addr,
  input  logic [XLEN-1:0] dbg_wdata,
  input  logic            dump_start,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic [AW-1:0]   rsp_addr,
  output logic            rsp_last
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NREGS - 1);

  dbg_state_e      state;
  dbg_cmd_t        cmd;
  logic [CNT_W-1:0] cnt;
  logic            dbg_reg_wr;
  logic [AW-1:0]   dbg_raddr1;

  // Debug-side port drive, derived from the current state and latched command.
  always_comb begin
    dbg_reg_wr = (state == ST_WR);
    dbg_raddr1 = (state == ST_DUMP_RD) ? cnt[AW-1:0] : cmd.addr;
  end

  regfile_port_mux u_port_mux (
    .sel         (halted),
    .core_reg_wr (core_reg_wr),
    .core_waddr  (core_waddr),
    .core_wdata  (core_wdata),
    .core_raddr1 (core_raddr1),
    .core_raddr2 (core_raddr2),
    .dbg_reg_wr  (dbg_reg_wr),
    .dbg_waddr   (cmd.addr),
    .dbg_wdata   (cmd.wdata),
    .dbg_raddr1  (dbg_raddr1),
    .rf_reg_wr   (rf_reg_wr),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .rf_raddr1   (rf_raddr1),
    .rf_raddr2   (rf_raddr2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      halted    <= 1'b0;
      dbg_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_addr  <= '0;
      rsp_last  <= 1'b0;
      cnt       <= '0;
      cmd       <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (halt_req) state <= ST_DRAIN;
        end
        // One extra pass-through cycle lets a core write already in flight land.
        ST_DRAIN: begin
          state     <= ST_HALT;
          halted    <= 1'b1;
          dbg_ready <= 1'b1;
        end
        ST_HALT: begin
          if (!halt_req) begin
            state     <= ST_RUN;
            halted    <= 1'b0;
            dbg_ready <= 1'b0;
          end else if (dump_start) begin
            state     <= ST_DUMP_RD;
            cnt       <= '0;
            dbg_ready <= 1'b0;
          end else if (dbg_valid) begin
            cmd       <= '{we: dbg_we, addr: dbg_addr, wdata: dbg_wdata};
            state     <= dbg_we ? ST_WR : ST_RD;
            dbg_ready <= 1'b0;
          end
        end
        ST_WR: begin
          rsp_valid <= 1'b1;
          rsp_data  <= (cmd.addr == '0) ? '0 : cmd.wdata;
          rsp_addr  <= cmd.addr;
          rsp_last  <= 1'b1;
          state     <= ST_RSP;
        end
        ST_RD: begin
          rsp_valid <= 1'b1;
          rsp_data  <= rf_rdata1;
          rsp_addr  <= cmd.addr;
          rsp_last  <= 1'b1;
          state     <= ST_RSP;
        end
        ST_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            dbg_ready <= 1'b1;
            state     <= ST_HALT;
          end
        end
        ST_DUMP_RD: begin
          rsp_valid <= 1'b1;
          rsp_data  <= rf_rdata1;
          rsp_addr  <= cnt[AW-1:0];
          rsp_last  <= (cnt == LAST_IDX);
          state     <= ST_DUMP_RSP;
        end
        ST_DUMP_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            if (cnt == LAST_IDX) begin
              cnt       <= '0;
              dbg_ready <= 1'b1;
              state     <= ST_HALT;
            end else begin
              cnt   <= cnt + CNT_W'(1);
              state <= ST_DUMP_RD;
            end
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dbg_access.sv
// Self-checking bench for regfile_dbg_access with an emulated register file and a
// register-contents reference model.
module tb_regfile_dbg_access;
  import regfile_dbg_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            halt_req;
  logic            halted;
  logic            core_reg_wr;
  logic [AW-1:0]   core_waddr;
  logic [XLEN-1:0] core_wdata;
  logic [AW-1:0]   core_raddr1;
  logic [AW-1:0]   core_raddr2;
  logic            rf_reg_wr;
  logic [AW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [AW-1:0]   rf_raddr1;
  logic [AW-1:0]   rf_raddr2;
  logic [XLEN-1:0] rf_rdata1;
  logic            dbg_valid;
  logic            dbg_ready;
  logic            dbg_we;
  logic [AW-1:0]   dbg_addr;
  logic [XLEN-1:0] dbg_wdata;
  logic            dump_start;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_data;
  logic [AW-1:0]   rsp_addr;
  logic            rsp_last;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [XLEN-1:0] mem   [NREGS] = '{default: '0};
  logic [XLEN-1:0] model [NREGS] = '{default: '0};

  always #5 clk = ~clk;

  regfile_dbg_access dut (
    .clk         (clk),
    .rst         (rst),
    .halt_req    (halt_req),
    .halted      (halted),
    .core_reg_wr (core_reg_wr),
    .core_waddr  (core_waddr),
    .core_wdata  (core_wdata),
    .core_raddr1 (core_raddr1),
    .core_raddr2 (core_raddr2),
    .rf_reg_wr   (rf_reg_wr),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .rf_raddr1   (rf_raddr1),
    .rf_raddr2   (rf_raddr2),
    .rf_rdata1   (rf_rdata1),
    .dbg_valid   (dbg_valid),
    .dbg_ready   (dbg_ready),
    .dbg_we      (dbg_we),
    .dbg_addr    (dbg_addr),
    .dbg_wdata   (dbg_wdata),
    .dump_start  (dump_start),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_addr    (rsp_addr),
    .rsp_last    (rsp_last)
  );

  // Register file: write commits on negedge, async read, x0 reads zero.
  always @(negedge clk) if (rf_reg_wr) mem[rf_waddr] <= rf_wdata;
  assign rf_rdata1 = (rf_raddr1 == '0) ? '0 : mem[rf_raddr1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic core_write(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    core_reg_wr = 1'b1;
    core_waddr  = a;
    core_wdata  = d;
    core_raddr1 = AW'($urandom);
    core_raddr2 = AW'($urandom);
    #1;
    chk("pass_wr", 64'({rf_reg_wr, rf_waddr, rf_wdata}), 64'({1'b1, a, d}));
    chk("pass_rd", 64'({rf_raddr1, rf_raddr2}), 64'({core_raddr1, core_raddr2}));
    step();
    if (a != '0) model[a] = d;
    core_reg_wr = 1'b0;
  endtask

  task automatic dbg_cmd(input logic we, input logic [AW-1:0] a, input logic [XLEN-1:0] d,
                         input int stall);
    logic [XLEN-1:0] exp;
    chk("cmd_ready", 64'(dbg_ready), 64'(1));
    dbg_valid = 1'b1;
    dbg_we    = we;
    dbg_addr  = a;
    dbg_wdata = d;
    step();
    dbg_valid = 1'b0;
    chk("cmd_busy", 64'({dbg_ready, rsp_valid}), 64'(0));
    if (we) begin
      chk("wr_port", 64'({rf_reg_wr, rf_waddr, rf_wdata}), 64'({1'b1, a, d}));
      if (a != '0) model[a] = d;
      exp = (a == '0) ? '0 : d;
    end else begin
      chk("rd_port", 64'({rf_reg_wr, rf_raddr1}), 64'({1'b0, a}));
      exp = model[a];
    end
    step();
    chk("rsp", 64'({rsp_valid, rsp_last, rsp_addr, rsp_data}), 64'({1'b1, 1'b1, a, exp}));
    chk("wr_pulse", 64'(rf_reg_wr), 64'(0));
    for (int k = 0; k < stall; k++) begin
      step();
      chk("rsp_hold", 64'({rsp_valid, rsp_last, rsp_addr, rsp_data}), 64'({1'b1, 1'b1, a, exp}));
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_done", 64'(rsp_valid), 64'(0));
  endtask

  task automatic dump(input int drop_beat, input bit with_cmd);
    int guard;
    dump_start = 1'b1;
    if (with_cmd) begin
      dbg_valid = 1'b1;
      dbg_we    = 1'b1;
      dbg_addr  = AW'(20);
      dbg_wdata = ~model[20];
    end
    step();
    dump_start = 1'b0;
    dbg_valid  = 1'b0;
    chk("dump_ready_drop", 64'(dbg_ready), 64'(0));
    for (int i = 0; i < int'(NREGS); i++) begin
      guard = 0;
      while (!rsp_valid && guard < 8) begin
        step();
        guard++;
      end
      chk("dump_valid", 64'(rsp_valid), 64'(1));
      chk("dump_beat", 64'({rsp_last, rsp_addr, rsp_data}),
          64'({(i == int'(NREGS) - 1), AW'(i), model[i]}));
      if (i == drop_beat) halt_req = 1'b0;
      if (i % 2 == 1) begin
        step();
        chk("dump_stall", 64'({rsp_valid, rsp_last, rsp_addr, rsp_data}),
            64'({1'b1, (i == int'(NREGS) - 1), AW'(i), model[i]}));
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("dump_gap", 64'(rsp_valid), 64'(0));
    end
  endtask

  initial begin
    int g;
    logic [AW-1:0]   a;
    logic            we;
    logic [XLEN-1:0] v;

    rst = 1'b1; halt_req = 1'b0; core_reg_wr = 1'b0; core_waddr = '0; core_wdata = '0;
    core_raddr1 = '0; core_raddr2 = '0; dbg_valid = 1'b0; dbg_we = 1'b0; dbg_addr = '0;
    dbg_wdata = '0; dump_start = 1'b0; rsp_ready = 1'b0;
    step();
    step();
    chk("reset_state", 64'({halted, dbg_ready, rsp_valid, rsp_last, rsp_addr, rsp_data}), 64'(0));
    rst = 1'b0;

    // Pass-through: populate every register from the core side.
    core_write(AW'(5), $urandom);
    for (int i = 0; i < int'(NREGS); i++) core_write(AW'(i), $urandom);
    chk("run_status", 64'({halted, dbg_ready, rsp_valid}), 64'(0));

    // Halt with a core write issued during the drain cycle.
    halt_req = 1'b1;
    step();
    chk("drain_not_halted", 64'(halted), 64'(0));
    v = $urandom;
    core_reg_wr = 1'b1; core_waddr = AW'(10); core_wdata = v; core_raddr2 = AW'(7);
    #1;
    chk("drain_pass", 64'({rf_reg_wr, rf_waddr, rf_wdata}), 64'({1'b1, AW'(10), v}));
    step();
    model[10] = v;
    chk("halted", 64'({halted, dbg_ready}), 64'({1'b1, 1'b1}));
    chk("halt_ports", 64'({rf_reg_wr, rf_raddr2}), 64'(0));
    core_reg_wr = 1'b0;

    dbg_cmd(1'b1, AW'(7), 32'hDEAD_BEEF, 2);
    dbg_cmd(1'b0, AW'(7), '0, 1);
    dbg_cmd(1'b0, AW'(10), '0, 0);
    dbg_cmd(1'b1, AW'(0), 32'h0000_1234, 0);
    dbg_cmd(1'b0, AW'(0), '0, 0);

    repeat (16) begin
      a  = AW'($urandom_range(31, 0));
      we = 1'($urandom_range(1, 0));
      dbg_cmd(we, a, $urandom, $urandom_range(2, 0));
      if (we) dbg_cmd(1'b0, a, '0, 0);
    end

    dump(-1, 1'b0);

    // Dump wins over a simultaneous command; halt drop mid-dump exits after completion.
    dump(10, 1'b1);
    g = 0;
    while (halted && g < 4) begin
      step();
      g++;
    end
    chk("exit_run", 64'({halted, dbg_ready}), 64'(0));
    core_raddr1 = AW'(3); core_raddr2 = AW'(4);
    #1;
    chk("exit_pass", 64'({rf_raddr1, rf_raddr2}), 64'({AW'(3), AW'(4)}));

    // Reset in the middle of a dump.
    halt_req = 1'b1;
    g = 0;
    while (!dbg_ready && g < 4) begin
      step();
      g++;
    end
    chk("rehalt", 64'(dbg_ready), 64'(1));
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    g = 0;
    while (!(rsp_valid && rsp_addr == AW'(12)) && g < 200) begin
      rsp_ready = rsp_valid;
      step();
      rsp_ready = 1'b0;
      g++;
    end
    chk("dump_at_12", 64'({rsp_valid, rsp_addr, rsp_data}), 64'({1'b1, AW'(12), model[12]}));
    v = $urandom | 32'h1;
    rst = 1'b1; halt_req = 1'b0;
    core_reg_wr = 1'b1; core_waddr = AW'(9); core_wdata = v;
    step();
    rst = 1'b0;
    chk("rst_status", 64'({halted, dbg_ready, rsp_valid, rsp_last, rsp_addr, rsp_data}), 64'(0));
    chk("rst_pass", 64'({rf_reg_wr, rf_waddr, rf_wdata}), 64'({1'b1, AW'(9), v}));
    step();
    model[9] = v;
    core_reg_wr = 1'b0;
    halt_req = 1'b1;
    step();
    step();
    dbg_cmd(1'b0, AW'(9), '0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
